// File: rtl/div_pkg.sv
// Shared types for the sequential signed/unsigned divider.
package div_pkg;

    localparam int DIV_DEF_WIDTH = 32;
    localparam int STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic           fits;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor};

    // When the subtraction fits, the result is below divisor and fits WIDTH bits.
    always_comb begin
        rem_out = shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_out = shifted[WIDTH-1:0] - divisor;
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle restoring divider, signed or unsigned per request.
// Define SDIV_DIVZERO_EN for a fast divide-by-zero path with err flag.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid,
    output logic             busy,
    output logic             ovf,
    output logic             err
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;

    logic             sgn_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic             qneg;
    logic             rneg;
    logic             ovf_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;
    logic             div_zero;

    assign a_neg = sgn_r & a_r[WIDTH-1];
    assign b_neg = sgn_r & b_r[WIDTH-1];
    assign a_mag = a_neg ? -a_r : a_r;
    assign b_mag = b_neg ? -b_r : b_r;

`ifdef SDIV_DIVZERO_EN
    assign div_zero = (b_r == '0);
`else
    assign div_zero = 1'b0;
    assign err      = 1'b0;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_r),
        .quo_in (quo_r),
        .divisor(b_r),
        .rem_out(rem_step),
        .quo_out(quo_step)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        valid    = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = PREP;
            end
            PREP: state_nx = div_zero ? DONE : ITER;
            ITER: if (cnt == CNT_W'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                valid    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            sgn_r     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            ovf_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
`ifdef SDIV_DIVZERO_EN
            err       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sgn_r <= sgn;
                        a_r   <= dividend;
                        b_r   <= divisor;
                    end
                end
                PREP: begin
                    quo_r <= a_mag;
                    rem_r <= '0;
                    b_r   <= b_mag;
                    qneg  <= a_neg ^ b_neg;
                    rneg  <= a_neg;
                    ovf_r <= sgn_r && (a_r == MOST_NEG) && (b_r == '1);
                    cnt   <= CNT_W'(WIDTH);
`ifdef SDIV_DIVZERO_EN
                    if (div_zero) begin
                        quotient  <= '1;
                        remainder <= a_r;
                        ovf       <= 1'b0;
                        err       <= 1'b1;
                    end
`endif
                end
                ITER: begin
                    quo_r <= quo_step;
                    rem_r <= rem_step;
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quotient  <= qneg ? -quo_r : quo_r;
                    remainder <= rneg ? -rem_r : rem_r;
                    ovf       <= ovf_r;
`ifdef SDIV_DIVZERO_EN
                    err       <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider with an arithmetic reference model.
module tb_seq_signed_divider;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         sgn;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         valid;
    logic         busy;
    logic         ovf;
    logic         err;

    typedef struct {
        int         due;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       o;
        logic       e;
    } exp_t;

    exp_t expq[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    bit   run_chk = 1'b0;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .sgn      (sgn),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .valid    (valid),
        .busy     (busy),
        .ovf      (ovf),
        .err      (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic void model(input logic s, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] q,
                                  output logic [W-1:0] r,
                                  output logic o, output logic e);
        longint sa, sb, lq, lr;
        o = 1'b0;
        e = 1'b0;
        q = '0;
        r = '0;
        if (b == '0) begin
            e = 1'b1;
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            o  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Caller sits just after a negedge with the DUT able to accept.
    task automatic issue(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold,
                         input bit lit, input logic [W-1:0] lq,
                         input logic [W-1:0] lr, input logic lo,
                         input logic le);
        exp_t         en;
        logic [W-1:0] mq, mr;
        logic         mo, me;
        int           acc;
        acc = cyc + hold;
        model(s, a, b, mq, mr, mo, me);
        en.q = lit ? lq : mq;
        en.r = lit ? lr : mr;
        en.o = lit ? lo : mo;
        en.e = lit ? le : me;
        en.due = acc + (en.e ? 1 : LAT);
        expq.push_back(en);
        start    = 1'b1;
        sgn      = s;
        dividend = a;
        divisor  = b;
        repeat (hold) @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", expq.size(), 0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic pin(input string name, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic eo);
        logic [W-1:0] q, r;
        logic         o, e;
        model(s, a, b, q, r, o, e);
        chk({name, "_q"}, q, eq);
        chk({name, "_r"}, r, er);
        chk({name, "_o"}, o, eo);
    endtask

    always @(negedge clock) begin
        if (run_chk) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("valid", valid, 1);
                chk("busy_done", busy, 1);
                chk("quotient", quotient, expq[0].q);
                chk("remainder", remainder, expq[0].r);
                chk("ovf", ovf, expq[0].o);
                chk("err", err, expq[0].e);
                void'(expq.pop_front());
            end else begin
                chk("valid_quiet", valid, 0);
            end
        end
    end

    typedef struct {
        logic       s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[5] = '{
        '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0},
        '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF},
        '{1'b0, 32'h5, 32'hA, 32'h0, 32'h5},
        '{1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1},
        '{1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF}
    };

    initial begin
        int acc;
        logic [W-1:0] ra, rb;
        reset    = 1'b1;
        start    = 1'b0;
        sgn      = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);

        pin("pin_u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        pin("pin_sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7,
            32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        pin("pin_s100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9,
            32'hFFFF_FFF2, 32'd2, 1'b0);
        pin("pin_sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'h0, 1'b1);
        pin("pin_uovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000, 1'b0);

        // Start on the very first edge after reset release.
        run_chk = 1'b1;
        reset   = 1'b1;
        issue(1'b0, 32'd100, 32'd7, 1, 1, 32'd14, 32'd2, 1'b0, 1'b0);
        drain();

        acc = cyc + 1;
        issue(1'b1, 32'hFFFF_FF9C, 32'd7, 1, 1,
              32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_cyc(acc + LAT);
        // Held start across DONE is taken only once back in IDLE.
        issue(1'b1, 32'd100, 32'hFFFF_FFF9, 2, 1,
              32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
        drain();

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1,
              32'h8000_0000, 32'h0, 1'b1, 1'b0);
        drain();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1,
              32'h0, 32'h8000_0000, 1'b0, 1'b0);
        drain();

        foreach (vecs[i]) begin
            issue(vecs[i].s, vecs[i].a, vecs[i].b, 1, 1,
                  vecs[i].q, vecs[i].r, 1'b0, 1'b0);
            drain();
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) rb = rb >> (i * 4);
            if (rb == '0) rb = 32'd3;
            issue(i[1], ra, rb, 1, 0, '0, '0, 1'b0, 1'b0);
            drain();
        end

        // A start during ITER must not disturb the operation in flight.
        issue(1'b0, 32'd100, 32'd7, 1, 1, 32'd14, 32'd2, 1'b0, 1'b0);
        repeat (8) @(negedge clock);
        start    = 1'b1;
        sgn      = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        @(negedge clock);
        start = 1'b0;
        drain();

`ifdef SDIV_DIVZERO_EN
        issue(1'b0, 32'd1234, 32'd0, 1, 1,
              32'hFFFF_FFFF, 32'd1234, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'hFFFF_FF9C, 32'd0, 1, 0, '0, '0, 1'b0, 1'b0);
        drain();
`endif

        // Reset in the middle of iteration 10.
        acc = cyc + 1;
        issue(1'b0, 32'd1000, 32'd3, 1, 0, '0, '0, 1'b0, 1'b0);
        wait_cyc(acc + 11);
        reset = 1'b0;
        #1;
        expq.delete();
        chk("mid_rst_quotient", quotient, 0);
        chk("mid_rst_remainder", remainder, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clock);
        reset = 1'b1;
        issue(1'b0, 32'd9, 32'd3, 1, 1, 32'd3, 32'd0, 1'b0, 1'b0);
        drain();

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
